rab_miss_fifo: RTL and testbench
================================

// Module: rab_miss_fifo
// PURPOSE
// - Miss-logging queue placed directly downstream of the RAB slice-lookup FSM.
// - Captures each translation-miss event (address, AXI ID, port) from int_miss/portN_miss/out_addr_reg.
// - Buffers events in FIFO order for the host-side miss handler, which pops them via a valid/ready read port.
// - Tracks overflow when events arrive faster than the handler drains them.
// PARAMETERS
// AXI_ADDR_WIDTH  40  width of logged miss address
// AXI_ID_WIDTH    8   width of logged AXI ID
// DEPTH           16  entries; power of two, >=2
// OVF_CNT_WIDTH   16  width of drop counter (only with RAB_MISS_OVF_CNT_EN)
// PORTS
// Clk_CI       in   1                   clock
// Rst_RBI      in   1                   async reset, active-low
// MissValid_SI in   1                   one-cycle miss event (from int_miss); no backpressure
// MissAddr_DI  in   AXI_ADDR_WIDTH      miss address (out_addr_reg)
// MissId_DI    in   AXI_ID_WIDTH        AXI ID of missing transaction
// MissPort_SI  in   1                   0 = port1, 1 = port2
// Flush_SI     in   1                   synchronous flush of all entries
// OvfClr_SI    in   1                   clears Overflow_SO (and OvfCnt_DO)
// RdValid_SO   out  1                   head entry valid (= !Empty_SO)
// RdReady_SI   in   1                   handler consumes head entry
// RdAddr_DO    out  AXI_ADDR_WIDTH      head entry address
// RdId_DO      out  AXI_ID_WIDTH        head entry ID
// RdPort_SO    out  1                   head entry port
// Empty_SO     out  1                   FIFO empty
// Full_SO      out  1                   FIFO full
// Count_DO     out  $clog2(DEPTH)+1     current occupancy
// Overflow_SO  out  1                   sticky: at least one miss dropped
// OvfCnt_DO    out  OVF_CNT_WIDTH       dropped-miss count (only with RAB_MISS_OVF_CNT_EN)
// BEHAVIOUR
// - Reset: pointers and Count_DO = 0; Empty_SO = 1; Full_SO = 0; RdValid_SO = 0.
//   Reset: Overflow_SO = 0; OvfCnt_DO = 0; Rd*_DO = 0 (storage cleared).
// - Pointers: log2(DEPTH)+1 bits each; MSB distinguishes full from empty.
//   Pointers wrap modulo 2*DEPTH; the storage index is the low bits.
// - Show-ahead read: Rd*_DO always reflect the head entry.
//   Pop = RdValid_SO & RdReady_SI; the next entry appears the cycle after the pop.
// - Push = MissValid_SI & (!Full_SO | pop).
//   Data is written at the write pointer; the entry is visible on Rd* the cycle after the push (latency 1).
// - Full and simultaneous push+pop: both are accepted; Count_DO is unchanged; order is preserved.
// - Empty and MissValid_SI: push only (no pop possible); RdValid_SO rises next cycle.
// - Drop = MissValid_SI & Full_SO & !pop.
//   On a drop, the entry is discarded and Overflow_SO is set next cycle.
// - Overflow_SO: set has priority over a same-cycle OvfClr_SI.
//   Not affected by Flush_SI.
// - Count_DO: +1 on push only; -1 on pop only; unchanged on both or neither.
//   Never exceeds DEPTH; never underflows (pop is gated by RdValid_SO).
// - Flush_SI: highest priority.
//   Next cycle, pointers and Count = 0 and Empty = 1.
//   Any same-cycle push/pop is ignored and does not count as a drop.
// - RdReady_SI while empty: ignored.
// - Reset mid-operation: all state returns to reset values immediately (async); queued entries are lost.
// CONFIGURATION
// - RAB_MISS_OVF_CNT_EN defined:
//   OvfCnt_DO is present; +1 per drop.
//   Saturates at 2^OVF_CNT_WIDTH-1.
//   Cleared by OvfClr_SI; increment wins over a same-cycle clear, leaving the count = 1.
// - RAB_MISS_OVF_CNT_EN undefined:
//   OvfCnt_DO port and counter are absent.
//   Overflow_SO remains as the sticky flag only.
// TESTING (bench uses DEPTH=4, AXI_ADDR_WIDTH=40, AXI_ID_WIDTH=8)
// - Push 0x10_0000_1000/ID 0x3/port 0, then 0x10_0000_2000/0x4/1, then 0x10_0000_3000/0x5/0.
//   -> Count_DO = 3; pops return the entries in order; Empty_SO = 1 after the third pop.
// - Push 5 misses with no pops
//   -> Full_SO = 1; Count_DO = 4; 5th dropped; Overflow_SO = 1; OvfCnt_DO = 1 (if _EN).
//   -> OvfClr_SI then clears both.
// - Full, MissValid_SI & RdReady_SI in the same cycle
//   -> no drop; Count_DO stays 4; head advances; new entry is read 4th.
// - Stream 10 entries (addr 0x0..0x9) with a pop every other cycle
//   -> pointers wrap; read sequence 0x0..0x9 with no loss or duplication.
// - Count_DO = 3, then Flush_SI with a same-cycle MissValid_SI
//   -> next cycle Count_DO = 0, Empty_SO = 1, Overflow_SO unchanged.
// - Count_DO = 2, Overflow_SO = 1, then Rst_RBI low mid-cycle
//   -> all outputs at reset values immediately.
//   -> after release, a push is readable one cycle later.

Source files
------------

// File: rtl/rab_miss_fifo_if.sv
// Interface bundling the miss-event write side and the handler read side of rab_miss_fifo.
// Optional macro RAB_MISS_OVF_CNT_EN adds the dropped-miss counter signal.
interface rab_miss_fifo_if #(
`ifdef RAB_MISS_OVF_CNT_EN
    parameter int OVF_CNT_WIDTH  = 16,
`endif
    parameter int AXI_ADDR_WIDTH = 40,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int DEPTH          = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                      MissValid_SI;
    logic [AXI_ADDR_WIDTH-1:0] MissAddr_DI;
    logic [AXI_ID_WIDTH-1:0]   MissId_DI;
    logic                      MissPort_SI;
    logic                      Flush_SI;
    logic                      OvfClr_SI;
    logic                      RdValid_SO;
    logic                      RdReady_SI;
    logic [AXI_ADDR_WIDTH-1:0] RdAddr_DO;
    logic [AXI_ID_WIDTH-1:0]   RdId_DO;
    logic                      RdPort_SO;
    logic                      Empty_SO;
    logic                      Full_SO;
    logic [CNT_W-1:0]          Count_DO;
    logic                      Overflow_SO;
`ifdef RAB_MISS_OVF_CNT_EN
    logic [OVF_CNT_WIDTH-1:0]  OvfCnt_DO;
`endif

    // Master is the miss source plus host handler; slave is the FIFO itself.
    modport master (
        output MissValid_SI, MissAddr_DI, MissId_DI, MissPort_SI,
        output Flush_SI, OvfClr_SI, RdReady_SI,
        input  RdValid_SO, RdAddr_DO, RdId_DO, RdPort_SO,
        input  Empty_SO, Full_SO, Count_DO, Overflow_SO
`ifdef RAB_MISS_OVF_CNT_EN
        , input OvfCnt_DO
`endif
    );

    modport slave (
        input  MissValid_SI, MissAddr_DI, MissId_DI, MissPort_SI,
        input  Flush_SI, OvfClr_SI, RdReady_SI,
        output RdValid_SO, RdAddr_DO, RdId_DO, RdPort_SO,
        output Empty_SO, Full_SO, Count_DO, Overflow_SO
`ifdef RAB_MISS_OVF_CNT_EN
        , output OvfCnt_DO
`endif
    );
endinterface

// File: rtl/rab_miss_fifo.sv
// Show-ahead FIFO logging RAB translation misses for the host-side miss handler.
// Optional macro RAB_MISS_OVF_CNT_EN adds a saturating dropped-miss counter.
module rab_miss_fifo #(
`ifdef RAB_MISS_OVF_CNT_EN
    parameter int OVF_CNT_WIDTH  = 16,
`endif
    parameter int AXI_ADDR_WIDTH = 40,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int DEPTH          = 16
) (
    input logic           Clk_CI,
    input logic           Rst_RBI,
    rab_miss_fifo_if.slave io_Bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]          r_WrPtr;
    logic [PTR_W-1:0]          r_RdPtr;
    logic [AXI_ADDR_WIDTH-1:0] r_Addr [DEPTH];
    logic [AXI_ID_WIDTH-1:0]   r_Id   [DEPTH];
    logic                      r_Port [DEPTH];
    logic                      r_Overflow;

    logic [PTR_W-1:0] w_Count;
    logic             w_Empty;
    logic             w_Full;
    logic             w_Pop;
    logic             w_Push;
    logic             w_Drop;
    logic [IDX_W-1:0] w_WrIdx;
    logic [IDX_W-1:0] w_RdIdx;

    // Pointers carry one extra wrap bit, so their difference is the occupancy 0..DEPTH.
    assign w_Count = r_WrPtr - r_RdPtr;
    assign w_Empty = (r_WrPtr == r_RdPtr);
    assign w_Full  = (w_Count == PTR_W'(DEPTH));
    assign w_WrIdx = r_WrPtr[IDX_W-1:0];
    assign w_RdIdx = r_RdPtr[IDX_W-1:0];

    assign w_Pop  = !w_Empty && io_Bus.RdReady_SI;
    assign w_Push = io_Bus.MissValid_SI && (!w_Full || w_Pop);
    assign w_Drop = io_Bus.MissValid_SI && w_Full && !w_Pop && !io_Bus.Flush_SI;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
        end else if (io_Bus.Flush_SI) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
        end else begin
            if (w_Push) begin
                r_WrPtr <= r_WrPtr + PTR_W'(1);
            end
            if (w_Pop) begin
                r_RdPtr <= r_RdPtr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_Addr[i] <= '0;
                r_Id[i]   <= '0;
                r_Port[i] <= 1'b0;
            end
        end else if (w_Push && !io_Bus.Flush_SI) begin
            r_Addr[w_WrIdx] <= io_Bus.MissAddr_DI;
            r_Id[w_WrIdx]   <= io_Bus.MissId_DI;
            r_Port[w_WrIdx] <= io_Bus.MissPort_SI;
        end
    end

    // A drop in the same cycle as a clear still leaves the flag set.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_Overflow <= 1'b0;
        end else if (w_Drop) begin
            r_Overflow <= 1'b1;
        end else if (io_Bus.OvfClr_SI) begin
            r_Overflow <= 1'b0;
        end
    end

`ifdef RAB_MISS_OVF_CNT_EN
    logic [OVF_CNT_WIDTH-1:0] r_OvfCnt;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_OvfCnt <= '0;
        end else if (w_Drop) begin
            if (io_Bus.OvfClr_SI) begin
                r_OvfCnt <= OVF_CNT_WIDTH'(1);
            end else if (r_OvfCnt != '1) begin
                r_OvfCnt <= r_OvfCnt + OVF_CNT_WIDTH'(1);
            end
        end else if (io_Bus.OvfClr_SI) begin
            r_OvfCnt <= '0;
        end
    end

    assign io_Bus.OvfCnt_DO = r_OvfCnt;
`endif

    assign io_Bus.RdValid_SO  = !w_Empty;
    assign io_Bus.RdAddr_DO   = r_Addr[w_RdIdx];
    assign io_Bus.RdId_DO     = r_Id[w_RdIdx];
    assign io_Bus.RdPort_SO   = r_Port[w_RdIdx];
    assign io_Bus.Empty_SO    = w_Empty;
    assign io_Bus.Full_SO     = w_Full;
    assign io_Bus.Count_DO    = w_Count;
    assign io_Bus.Overflow_SO = r_Overflow;
endmodule

// File: tb/tb_rab_miss_fifo.sv
// Scoreboard bench for rab_miss_fifo (DEPTH=4): directed scenarios followed by random traffic.
module tb_rab_miss_fifo;
    localparam int DEPTH   = 4;
    localparam int AW      = 40;
    localparam int IW      = 8;
    localparam int OVF_MAX = 65535;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic          port;
    } entry_t;

    logic   Clk_CI  = 1'b0;
    logic   Rst_RBI = 1'b1;
    int     nChecks = 0;
    int     nFails  = 0;

    entry_t sbQ[$];
    int     mCount  = 0;
    bit     mOvf    = 1'b0;
    int     mOvfCnt = 0;

    rab_miss_fifo_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    rab_miss_fifo #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .Clk_CI (Clk_CI),
        .Rst_RBI(Rst_RBI),
        .io_Bus (bus)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return #1 after the edge that consumed them.
    task automatic applyStimulus(input logic mv, input logic [AW-1:0] a, input logic [IW-1:0] id,
                                 input logic p, input logic rdy, input logic fl, input logic clr);
        bus.MissValid_SI = mv;
        bus.MissAddr_DI  = a;
        bus.MissId_DI    = id;
        bus.MissPort_SI  = p;
        bus.RdReady_SI   = rdy;
        bus.Flush_SI     = fl;
        bus.OvfClr_SI    = clr;
        @(posedge Clk_CI);
        #1;
    endtask

    // Reference model: occupancy count, expected-entry queue, sticky flag and drop counter.
    initial begin
        forever begin
            @(posedge Clk_CI or negedge Rst_RBI);
            if (!Rst_RBI) begin
                mCount  = 0;
                mOvf    = 1'b0;
                mOvfCnt = 0;
                sbQ.delete();
            end else begin
                bit pop, push, drop;
                pop  = (mCount > 0) && bus.RdReady_SI;
                push = 1'b0;
                drop = 1'b0;
                if (bus.Flush_SI) begin
                    mCount = 0;
                    sbQ.delete();
                end else begin
                    push = bus.MissValid_SI && ((mCount < DEPTH) || pop);
                    drop = bus.MissValid_SI && (mCount == DEPTH) && !pop;
                    if (push) begin
                        sbQ.push_back('{addr: bus.MissAddr_DI, id: bus.MissId_DI, port: bus.MissPort_SI});
                    end
                    mCount = mCount + int'(push) - int'(pop);
                end
                if (drop) begin
                    mOvf    = 1'b1;
                    mOvfCnt = bus.OvfClr_SI ? 1 : ((mOvfCnt == OVF_MAX) ? mOvfCnt : mOvfCnt + 1);
                end else if (bus.OvfClr_SI) begin
                    mOvf    = 1'b0;
                    mOvfCnt = 0;
                end
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each observed handshake.
    initial begin
        forever begin
            @(negedge Clk_CI);
            checkVal("count", 64'(bus.Count_DO), 64'(mCount));
            checkVal("empty", 64'(bus.Empty_SO), 64'(mCount == 0));
            checkVal("full", 64'(bus.Full_SO), 64'(mCount == DEPTH));
            checkVal("rdvalid", 64'(bus.RdValid_SO), 64'(mCount > 0));
            checkVal("overflow", 64'(bus.Overflow_SO), 64'(mOvf));
`ifdef RAB_MISS_OVF_CNT_EN
            checkVal("ovfcnt", 64'(bus.OvfCnt_DO), 64'(mOvfCnt));
`endif
            if (Rst_RBI && bus.RdValid_SO && bus.RdReady_SI && !bus.Flush_SI) begin
                if (sbQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL read_underrun: got addr 0x%0h, expected no entry", bus.RdAddr_DO);
                end else begin
                    entry_t e;
                    e = sbQ.pop_front();
                    checkVal("rd_addr", 64'(bus.RdAddr_DO), 64'(e.addr));
                    checkVal("rd_id", 64'(bus.RdId_DO), 64'(e.id));
                    checkVal("rd_port", 64'(bus.RdPort_SO), 64'(e.port));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.MissValid_SI = 1'b0;
        bus.MissAddr_DI  = '0;
        bus.MissId_DI    = '0;
        bus.MissPort_SI  = 1'b0;
        bus.RdReady_SI   = 1'b0;
        bus.Flush_SI     = 1'b0;
        bus.OvfClr_SI    = 1'b0;
        #1 Rst_RBI = 1'b0;
        repeat (2) @(posedge Clk_CI);
        #1;
        checkVal("reset_empty", 64'(bus.Empty_SO), 64'd1);
        checkVal("reset_rdaddr", 64'(bus.RdAddr_DO), 64'd0);
        Rst_RBI = 1'b1;
        applyStimulus(0, '0, '0, 0, 0, 0, 0);

        // Three pushes, then three in-order pops.
        applyStimulus(1, 40'h10_0000_1000, 8'h3, 0, 0, 0, 0);
        applyStimulus(1, 40'h10_0000_2000, 8'h4, 1, 0, 0, 0);
        applyStimulus(1, 40'h10_0000_3000, 8'h5, 0, 0, 0, 0);
        checkVal("s1_count", 64'(bus.Count_DO), 64'd3);
        repeat (3) applyStimulus(0, '0, '0, 0, 1, 0, 0);
        checkVal("s1_empty", 64'(bus.Empty_SO), 64'd1);

        // Five pushes with no pops: the fifth is dropped.
        for (int i = 0; i < 5; i++) applyStimulus(1, 40'h20_0000_0000 + AW'(i), IW'(i), i[0], 0, 0, 0);
        checkVal("s2_full", 64'(bus.Full_SO), 64'd1);
        checkVal("s2_count", 64'(bus.Count_DO), 64'd4);
        checkVal("s2_overflow", 64'(bus.Overflow_SO), 64'd1);
`ifdef RAB_MISS_OVF_CNT_EN
        checkVal("s2_ovfcnt", 64'(bus.OvfCnt_DO), 64'd1);
`endif
        applyStimulus(0, '0, '0, 0, 0, 0, 1);
        checkVal("s2_ovfclr", 64'(bus.Overflow_SO), 64'd0);

        // Full with simultaneous push and pop: no drop, new entry becomes fourth.
        applyStimulus(1, 40'h30_0000_0000, 8'h77, 1, 1, 0, 0);
        checkVal("s3_count", 64'(bus.Count_DO), 64'd4);
        checkVal("s3_nodrop", 64'(bus.Overflow_SO), 64'd0);
        repeat (4) applyStimulus(0, '0, '0, 0, 1, 0, 0);

        // Stream ten entries with a pop every other cycle; pointers wrap.
        for (int i = 0; i < 20; i++) applyStimulus(~i[0], AW'(i / 2), IW'(i), 0, i[0], 0, 0);
        repeat (2) applyStimulus(0, '0, '0, 0, 1, 0, 0);
        checkVal("s4_empty", 64'(bus.Empty_SO), 64'd1);

        // Count 3 with Overflow set, then flush alongside a miss.
        for (int i = 0; i < 5; i++) applyStimulus(1, 40'h40_0000_0000 + AW'(i), IW'(i), 0, 0, 0, 0);
        applyStimulus(0, '0, '0, 0, 1, 0, 0);
        checkVal("s5_count", 64'(bus.Count_DO), 64'd3);
        applyStimulus(1, 40'h4F_0000_0000, 8'hEE, 1, 0, 1, 0);
        checkVal("s5_flush_count", 64'(bus.Count_DO), 64'd0);
        checkVal("s5_flush_empty", 64'(bus.Empty_SO), 64'd1);
        checkVal("s5_flush_ovf", 64'(bus.Overflow_SO), 64'd1);

        // Asynchronous reset mid-cycle with two entries queued.
        applyStimulus(1, 40'h50_0000_0001, 8'h11, 0, 0, 0, 0);
        applyStimulus(1, 40'h50_0000_0002, 8'h22, 1, 0, 0, 0);
        checkVal("s6_count", 64'(bus.Count_DO), 64'd2);
        #2 Rst_RBI = 1'b0;
        #1;
        checkVal("s6_rst_count", 64'(bus.Count_DO), 64'd0);
        checkVal("s6_rst_empty", 64'(bus.Empty_SO), 64'd1);
        checkVal("s6_rst_full", 64'(bus.Full_SO), 64'd0);
        checkVal("s6_rst_valid", 64'(bus.RdValid_SO), 64'd0);
        checkVal("s6_rst_ovf", 64'(bus.Overflow_SO), 64'd0);
        checkVal("s6_rst_addr", 64'(bus.RdAddr_DO), 64'd0);
        checkVal("s6_rst_id", 64'(bus.RdId_DO), 64'd0);
        checkVal("s6_rst_port", 64'(bus.RdPort_SO), 64'd0);
        @(posedge Clk_CI);
        #1 Rst_RBI = 1'b1;
        applyStimulus(1, 40'hAB_CDEF_0123, 8'h5A, 1, 0, 0, 0);
        checkVal("s6_post_valid", 64'(bus.RdValid_SO), 64'd1);
        checkVal("s6_post_addr", 64'(bus.RdAddr_DO), 64'hAB_CDEF_0123);
        checkVal("s6_post_id", 64'(bus.RdId_DO), 64'h5A);
        applyStimulus(0, '0, '0, 0, 1, 0, 0);

        // Random traffic with varying drain pressure.
        for (int i = 0; i < 600; i++) begin
            int unsigned thr;
            thr = 32'(i / 100) % 4;
            applyStimulus(1'($urandom_range(0, 1)),
                          {8'($urandom), 32'($urandom)},
                          8'($urandom),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) < thr),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 19) == 0));
        end
        repeat (DEPTH + 2) applyStimulus(0, '0, '0, 0, 1, 0, 0);
        checkVal("drain_scoreboard", 64'(sbQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
